// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulator block.
//   mac_state_t : top-level control states
//   MAC_*       : default parameter values for operand, accumulator, counter
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2,
        HOLD = 2'd3
    } mac_state_t;

    localparam int MAC_WIDTH = 8;
    localparam int MAC_ACC_W = 24;
    localparam int MAC_CNT_W = 8;

endpackage

// File: rtl/mac_accumulator_mult.sv
// Sequential shift-add multiplier, unsigned, fixed WIDTH-cycle latency.
//   clk, rst_n : clock, async active-low reset
//   start      : capture a/b and begin (ignored only by the caller's gating)
//   a, b       : operands; b is consumed LSB first
//   busy       : a multiply is in progress
//   done       : high during the cycle whose edge performs the final step
//   product    : 2*WIDTH-bit result, valid after the edge where done was high
module shift_add_mult #(
    parameter int WIDTH = mac_pkg::MAC_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               last_step;

    // No early exit: every multiply takes exactly WIDTH steps.
    assign last_step = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= (2*WIDTH)'(a);
            mplier_q <= b;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_step) busy_q <= 1'b0;
        end
    end

    assign busy    = busy_q;
    assign done    = last_step;
    assign product = prod_q;

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate over batches of operand pairs.
//   in_valid/in_ready/in_a/in_b/in_last : operand pair handshake
//   out_valid/out_ready                  : batch result handshake
//   out_acc   : running sum of products, modulo 2^ACC_W
//   out_count : running pair count, saturating
//   out_ovf   : sticky carry-out of the accumulator within the batch
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int ACC_W = MAC_ACC_W,
    parameter int CNT_W = MAC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    mac_state_t         state_q;
    logic               in_ready_q, out_valid_q, last_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum_w;

    logic               mult_start, mult_busy, mult_done;
    logic [2*WIDTH-1:0] mult_product;

    assign mult_start = in_valid && in_ready_q && !mult_busy;

    shift_add_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mult_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    // One extra bit on the adder exposes the carry out of the accumulator.
    always_comb begin
        sum_w = {1'b0, acc_q} + (ACC_W+1)'(mult_product);
        acc_d = sum_w[ACC_W-1:0];
        ovf_d = ovf_q | sum_w[ACC_W];
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (mult_start) begin
                    last_q     <= in_last;
                    in_ready_q <= 1'b0;
                    state_q    <= MULT;
                end
                MULT: if (mult_done) state_q <= ACC;
                ACC: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_d;
                    if (last_q) begin
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                HOLD: if (out_ready) begin
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;
    localparam int W  = 8;
    localparam int AW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_acc;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mac_accumulator #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  a, b;
        logic          last;
        logic [AW-1:0] acc;
        logic [CW-1:0] cnt;
        logic          ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns at the negedge after the accepting edge, with that edge's cycle index.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                        output int acc_cyc);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_last = 1'($urandom);
    endtask

    task automatic wait_out(output int seen_cyc);
        int n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("out_valid_wait", out_valid, 1);
        seen_cyc = cyc;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_acc", out_acc, 0);
        chk("post_hs_count", out_count, 0);
        chk("post_hs_ovf", out_ovf, 0);
    endtask

    initial begin
        int t0, t1, prev_cyc;
        bit prev_nonlast;

        vecs[0]  = '{8'd10,  8'd99,  1'b1, 16'd990,   8'd1, 1'b0};
        vecs[1]  = '{8'd10,  8'd99,  1'b0, 16'd0,     8'd0, 1'b0};
        vecs[2]  = '{8'd132, 8'd33,  1'b0, 16'd0,     8'd0, 1'b0};
        vecs[3]  = '{8'd16,  8'd4,   1'b1, 16'd5410,  8'd3, 1'b0};
        vecs[4]  = '{8'd255, 8'd255, 1'b0, 16'd0,     8'd0, 1'b0};
        vecs[5]  = '{8'd255, 8'd255, 1'b1, 16'd64514, 8'd2, 1'b1};
        vecs[6]  = '{8'd1,   8'd1,   1'b1, 16'd1,     8'd1, 1'b0};
        vecs[7]  = '{8'd0,   8'd77,  1'b1, 16'd0,     8'd1, 1'b0};
        vecs[8]  = '{8'd255, 8'd1,   1'b1, 16'd255,   8'd1, 1'b0};
        vecs[9]  = '{8'd0,   8'd0,   1'b0, 16'd0,     8'd0, 1'b0};
        vecs[10] = '{8'd255, 8'd255, 1'b1, 16'd65025, 8'd2, 1'b0};

        // Reset state, observed while reset is held
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc", out_acc, 0);
        chk("rst_count", out_count, 0);
        chk("rst_ovf", out_ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        prev_nonlast = 1'b0; prev_cyc = 0;
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].last, t0);
            chk("busy_in_ready", in_ready, 0);
            if (prev_nonlast) chk("accept_spacing", t0 - prev_cyc, 10);
            prev_cyc = t0;
            prev_nonlast = !vecs[i].last;
            if (vecs[i].last) begin
                wait_out(t1);
                chk("latency", t1 - t0, 9);
                chk("acc", out_acc, vecs[i].acc);
                chk("count", out_count, vecs[i].cnt);
                chk("ovf", out_ovf, vecs[i].ovf);
                chk("hold_in_ready", in_ready, 0);
                release_out();
            end
        end

        // Backpressure: result held, stray input pulses ignored
        send(8'd7, 8'd6, 1'b1, t0);
        wait_out(t1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_a = 8'd50; in_b = 8'd50; in_last = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_acc", out_acc, 42);
            chk("bp_count", out_count, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        release_out();
        send(8'd2, 8'd2, 1'b1, t0);
        wait_out(t1);
        chk("after_bp_acc", out_acc, 4);
        chk("after_bp_count", out_count, 1);
        release_out();

        // Reset in the middle of a multiply discards the partial batch
        send(8'd100, 8'd100, 1'b0, t0);
        send(8'd200, 8'd200, 1'b1, t0);
        chk("pre_rst_acc", out_acc, 10000);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_acc", out_acc, 0);
        chk("async_rst_count", out_count, 0);
        chk("async_rst_ovf", out_ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        send(8'd3, 8'd5, 1'b1, t0);
        wait_out(t1);
        chk("post_rst_latency", t1 - t0, 9);
        chk("post_rst_acc", out_acc, 15);
        chk("post_rst_count", out_count, 1);
        chk("post_rst_ovf", out_ovf, 0);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
